// File: rtl/seq_mag_compare_if.sv
// Operand/result bundle for seq_mag_compare. The sgn line exists only when
// SEQ_CMP_SIGNED_EN is defined.
interface seq_mag_compare_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             gt_in;
  logic             lt_in;
  logic             eq_in;
`ifdef SEQ_CMP_SIGNED_EN
  logic             sgn;
`endif
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;

  modport master (
    output start, a, b, gt_in, lt_in, eq_in,
`ifdef SEQ_CMP_SIGNED_EN
    output sgn,
`endif
    input  busy, done, gt, lt, eq
  );

  modport slave (
    input  start, a, b, gt_in, lt_in, eq_in,
`ifdef SEQ_CMP_SIGNED_EN
    input  sgn,
`endif
    output busy, done, gt, lt, eq
  );
endinterface

// File: rtl/seq_mag_compare.sv
// Multi-cycle MSB-first magnitude comparator with 7485-style cascade inputs.
// Optional signed MSB-slice compare is enabled by defining SEQ_CMP_SIGNED_EN.
module seq_mag_compare #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic          clk,
  input logic          rst,
  seq_mag_compare_if.slave bus
);
  localparam int NS   = WIDTH / SLICE;
  localparam int IDXW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IDXW-1:0] IDX_MSB = IDXW'(NS - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       casc_q, casc_d;
  logic [2:0]       res_q, res_d;
  logic [SLICE-1:0] sa, sb;
  logic [2:0]       casc_res;
`ifdef SEQ_CMP_SIGNED_EN
  logic             sgn_q, sgn_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= IDX_MSB;
      a_q     <= '0;
      b_q     <= '0;
      casc_q  <= '0;
      res_q   <= '0;
`ifdef SEQ_CMP_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      casc_q  <= casc_d;
      res_q   <= res_d;
`ifdef SEQ_CMP_SIGNED_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  // Signed MSB slice: inverting the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    sa = a_q[SLICE*int'(idx_q) +: SLICE];
    sb = b_q[SLICE*int'(idx_q) +: SLICE];
`ifdef SEQ_CMP_SIGNED_EN
    if (sgn_q && (idx_q == IDX_MSB)) begin
      sa[SLICE-1] = ~sa[SLICE-1];
      sb[SLICE-1] = ~sb[SLICE-1];
    end
`endif
  end

  // casc_q is {gt_in, lt_in, eq_in}; eq_in dominates, otherwise gt/lt are the inverted opposite inputs.
  always_comb begin
    casc_res[0] = casc_q[0];
    casc_res[2] = ~casc_q[0] & ~casc_q[1];
    casc_res[1] = ~casc_q[0] & ~casc_q[2];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    casc_d  = casc_q;
    res_d   = res_q;
`ifdef SEQ_CMP_SIGNED_EN
    sgn_d   = sgn_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          casc_d  = {bus.gt_in, bus.lt_in, bus.eq_in};
`ifdef SEQ_CMP_SIGNED_EN
          sgn_d   = bus.sgn;
`endif
          idx_d   = IDX_MSB;
          state_d = CMP;
        end
      end
      CMP: begin
        if (sa > sb) begin
          res_d   = 3'b100;
          state_d = DONE;
        end else if (sa < sb) begin
          res_d   = 3'b010;
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_d   = casc_res;
          state_d = DONE;
        end else begin
          idx_d   = idx_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
    bus.gt   = res_q[2];
    bus.lt   = res_q[1];
    bus.eq   = res_q[0];
  end
endmodule

// File: doc/seq_mag_compare.md
# seq_mag_compare

Parametrised, multi-cycle magnitude comparator. It is the next generation of the team's 4-bit cascadable comparator.
- Two WIDTH-bit operands are latched on a start strobe.
- The operands are compared one SLICE-bit slice per clock, from MSB to LSB, stopping at the first unequal slice.
- The result is reported as one-hot gt/lt/eq with a done pulse.
- Cascade inputs keep the classic 7485 semantics, so several units (or legacy 4-bit stages) can be chained for wider words.

## Interface
Reset is synchronous and active-high on `rst`. The block uses a single clock, `clk`.

Parameters:
- WIDTH, 16, operand width; must be a multiple of SLICE.
- SLICE, 4, bits compared per cycle. NS = WIDTH/SLICE slices.

Ports:
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a compare; accepted only in IDLE
- a  input  WIDTH  operand A, sampled on the accepted start
- b  input  WIDTH  operand B, sampled on the accepted start
- gt_in  input  1  cascade "A>B" from the less-significant stage, sampled on start
- lt_in  input  1  cascade "A<B", sampled on start
- eq_in  input  1  cascade "A=B", sampled on start
- sgn  input  1  two's-complement compare when 1 (present only with SEQ_CMP_SIGNED_EN), sampled on start
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse: result is valid
- gt  output  1  A>B
- lt  output  1  A<B
- eq  output  1  A=B

## Operation
The state machine has three states: IDLE, CMP, DONE.
- **IDLE**
  - When start=1, latch a, b, the cascade inputs and sgn.
  - Set idx = NS-1 and go to CMP.
  - When start=0, stay in IDLE.
- **CMP**: each cycle, compare slice idx of A with slice idx of B.
  - Unequal slice: write the one-hot gt/lt result and go to DONE.
  - Equal slice with idx=0: write the cascade result (below) and go to DONE.
  - Otherwise: idx decrements and the FSM stays in CMP.
- **DONE**: done=1 for this cycle only, then go to IDLE unconditionally.
- A start while busy=1 (CMP or DONE) is ignored. No queueing.
- Cascade resolution, applied only when all slices are equal (same as the legacy 4-bit part). Notation is {gt_in,lt_in,eq_in} -> {gt,lt,eq}:
  - eq_in=1 -> 001, regardless of the other two inputs.
  - 100 -> 100
  - 010 -> 010
  - 110 -> 000
  - 000 -> 110
- gt, lt and eq are registered. They hold their value from the DONE cycle until the next DONE; they do not clear on start.

## Timing
- Reset values: state=IDLE, busy=0, done=0, gt=0, lt=0, eq=0, idx=NS-1.
- Edge numbering: the edge that samples start is edge 0.
- With k slices examined (1 ≤ k ≤ NS):
  - gt/lt/eq update on edge k.
  - done is high during the cycle after edge k.
  - busy is high from after edge 0 until edge k+1.
- Best-case latency is 1 slice, worst case NS slices. For WIDTH=16, SLICE=4: done arrives 1..4 cycles after start.
- Minimum start-to-start spacing is k+2 cycles. A start is accepted in the cycle after done is high, never in the done cycle itself.
- Reset asserted mid-operation:
  - The next edge forces all reset values.
  - The in-flight result is discarded and no done pulse is emitted.
- Reset and start in the same cycle: reset wins and the start is dropped.

## Configuration
- Macro SEQ_CMP_SIGNED_EN.
- Defined:
  - The sgn port exists.
  - When the latched sgn=1, the MSB slice (idx=NS-1) is compared as a signed SLICE-bit value; all lower slices are compared unsigned.
  - The cascade rules are unchanged.
- Undefined:
  - The sgn port is absent.
  - All slices are compared unsigned.
  - No signed logic is synthesised.

## Test plan
All scenarios use WIDTH=16, SLICE=4.
- a=16'h5A3C, b=16'h5A3C, cascade 001 -> gt/lt/eq=001; done high in the cycle after edge 4; busy high for 5 cycles.
- a=16'h8000, b=16'h7FFF, unsigned -> 100 with done after edge 1. With SEQ_CMP_SIGNED_EN and sgn=1 -> 010.
- a=16'h1234, b=16'h1244 -> 010 with done after edge 3; a second start pulsed while busy=1 is ignored and produces no extra done.
- Equal operands (16'hBEEF) with each cascade code:
  - 100 -> 100
  - 010 -> 010
  - 101 -> 001
  - 111 -> 001
  - 110 -> 000
  - 000 -> 110
- Start with a=16'h0001, b=16'h0000, then assert rst after edge 2 -> no done pulse; all outputs 0 on the following cycle; a fresh start then yields 100 after edge 4.
- Back-to-back: start accepted on the cycle after done -> second result correct, with no state carried over from the first compare.
